// File: rtl/trap_sequencer.sv
// Trap and return sequencer: arbitrates exceptions, xRET requests and
// pending interrupts, drains the pipeline through a flush handshake, then
// issues a single-cycle strobe (with redirect) into the CSR file.
module trap_sequencer #(
   parameter int unsigned HOLDOFF = 2
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        exc_valid,
   input  logic [4:0]  exc_code,
   input  logic [31:0] exc_pc,
   input  logic        ret_valid,
   input  logic [1:0]  ret_type,
   input  logic        commit_valid,
   input  logic [31:0] commit_pc,
   input  logic        m_interrupt,
   input  logic        s_interrupt,
   input  logic        u_interrupt,
   input  logic        u_soft,
   input  logic        m_timer,
   input  logic        s_timer,
   input  logic        u_timer,
   input  logic        m_eie,
   input  logic        m_tie,
   input  logic        s_eie,
   input  logic        s_tie,
   input  logic        u_eie,
   input  logic        u_tie,
   input  logic        u_sie,
   input  logic        flush_ack,
   output logic        flush_req,
   output logic        ready,
   output logic        exception_pending,
   output logic [31:0] cause,
   output logic [31:0] pc_exc,
   output logic        m_ret,
   output logic        s_ret,
   output logic        u_ret,
   output logic        redirect
);

   typedef enum logic [1:0] {IDLE, FLUSH, TRAP, RET} state_t;

   localparam logic [3:0] HOLDOFF_INIT = 4'(HOLDOFF);

   state_t      state_reg, state_next;
   logic        kind_ret_reg, kind_ret_next;
   logic [1:0]  ret_type_reg, ret_type_next;
   logic [31:0] cause_reg, cause_next;
   logic [31:0] pc_exc_reg, pc_exc_next;
   logic [3:0]  holdoff_cnt_reg, holdoff_cnt_next;

   // Pending vector in priority order: MEI, MTI, SEI, STI, UEI, USI, UTI
   logic [6:0] int_pend;
   logic       int_any;
   logic [4:0] int_code;

   assign int_pend = {m_interrupt & m_eie, m_timer & m_tie, s_interrupt & s_eie,
                      s_timer & s_tie, u_interrupt & u_eie, u_soft & u_sie,
                      u_timer & u_tie};
   assign int_any  = |int_pend;

   // Pick the highest-priority pending interrupt code
   always_comb begin
      int_code = 5'd0;
      if (int_pend[6])      int_code = 5'd11;
      else if (int_pend[5]) int_code = 5'd7;
      else if (int_pend[4]) int_code = 5'd9;
      else if (int_pend[3]) int_code = 5'd5;
      else if (int_pend[2]) int_code = 5'd8;
      else if (int_pend[1]) int_code = 5'd0;
      else if (int_pend[0]) int_code = 5'd4;
   end

   // State and latched-event registers; reset aborts any sequence in flight
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg       <= IDLE;
         kind_ret_reg    <= 1'b0;
         ret_type_reg    <= 2'b00;
         cause_reg       <= 32'd0;
         pc_exc_reg      <= 32'd0;
         holdoff_cnt_reg <= 4'd0;
      end else begin
         state_reg       <= state_next;
         kind_ret_reg    <= kind_ret_next;
         ret_type_reg    <= ret_type_next;
         cause_reg       <= cause_next;
         pc_exc_reg      <= pc_exc_next;
         holdoff_cnt_reg <= holdoff_cnt_next;
      end
   end

   // Arbitration in IDLE, flush wait, and strobe-then-return sequencing
   always_comb begin
      state_next       = state_reg;
      kind_ret_next    = kind_ret_reg;
      ret_type_next    = ret_type_reg;
      cause_next       = cause_reg;
      pc_exc_next      = pc_exc_reg;
      holdoff_cnt_next = holdoff_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (holdoff_cnt_reg != 4'd0)
               holdoff_cnt_next = holdoff_cnt_reg - 4'd1;
            if (exc_valid) begin
               cause_next    = {27'd0, exc_code};
               pc_exc_next   = exc_pc;
               kind_ret_next = 1'b0;
               state_next    = FLUSH;
            end else if (ret_valid) begin
               ret_type_next = ret_type;
               kind_ret_next = 1'b1;
               state_next    = FLUSH;
            end else if (int_any && commit_valid && (holdoff_cnt_reg == 4'd0)) begin
               cause_next    = {1'b1, 26'd0, int_code};
               pc_exc_next   = commit_pc;
               kind_ret_next = 1'b0;
               state_next    = FLUSH;
            end
         end
         FLUSH: begin
            if (flush_ack)
               state_next = kind_ret_reg ? RET : TRAP;
         end
         TRAP, RET: begin
            holdoff_cnt_next = HOLDOFF_INIT;
            state_next       = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Moore outputs; the illegal xRET encoding 10 behaves as MRET
   assign ready             = (state_reg == IDLE);
   assign flush_req         = (state_reg == FLUSH);
   assign exception_pending = (state_reg == TRAP) || (state_reg == RET);
   assign redirect          = exception_pending;
   assign m_ret             = (state_reg == RET) && ret_type_reg[1];
   assign s_ret             = (state_reg == RET) && (ret_type_reg == 2'b01);
   assign u_ret             = (state_reg == RET) && (ret_type_reg == 2'b00);
   assign cause             = cause_reg;
   assign pc_exc            = pc_exc_reg;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: randomized events checked against
// a transaction-level model of the arbitration and strobe rules.
module tb_trap_sequencer;

   localparam int HOLDOFF = 2;

   logic        clk, nrst;
   logic        exc_valid, ret_valid, commit_valid, flush_ack;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc, commit_pc;
   logic [1:0]  ret_type;
   logic        m_interrupt, s_interrupt, u_interrupt, u_soft;
   logic        m_timer, s_timer, u_timer;
   logic        m_eie, m_tie, s_eie, s_tie, u_eie, u_tie, u_sie;
   logic        flush_req, ready, exception_pending, redirect;
   logic        m_ret, s_ret, u_ret;
   logic [31:0] cause, pc_exc;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_cause = 32'd0;
   logic [31:0] exp_pc    = 32'd0;
   logic        prev_strobe = 1'b0;

   trap_sequencer #(.HOLDOFF(HOLDOFF)) dut (
      .clk(clk), .nrst(nrst),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
      .ret_valid(ret_valid), .ret_type(ret_type),
      .commit_valid(commit_valid), .commit_pc(commit_pc),
      .m_interrupt(m_interrupt), .s_interrupt(s_interrupt),
      .u_interrupt(u_interrupt), .u_soft(u_soft),
      .m_timer(m_timer), .s_timer(s_timer), .u_timer(u_timer),
      .m_eie(m_eie), .m_tie(m_tie), .s_eie(s_eie), .s_tie(s_tie),
      .u_eie(u_eie), .u_tie(u_tie), .u_sie(u_sie),
      .flush_ack(flush_ack), .flush_req(flush_req), .ready(ready),
      .exception_pending(exception_pending), .cause(cause), .pc_exc(pc_exc),
      .m_ret(m_ret), .s_ret(s_ret), .u_ret(u_ret), .redirect(redirect)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pending interrupts listed from highest to lowest priority
   function automatic logic [6:0] pend_vec();
      return {m_interrupt & m_eie, m_timer & m_tie, s_interrupt & s_eie,
              s_timer & s_tie, u_interrupt & u_eie, u_soft & u_sie,
              u_timer & u_tie};
   endfunction

   function automatic logic [31:0] int_cause(input logic [6:0] pend);
      int codes [7];
      codes = '{11, 7, 9, 5, 8, 0, 4};
      for (int i = 0; i < 7; i++)
         if (pend[6-i]) return 32'h8000_0000 | 32'(codes[i]);
      return 32'd0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      exc_valid = 0; ret_valid = 0; commit_valid = 0; flush_ack = 0;
      exc_code = 0; exc_pc = 0; ret_type = 0; commit_pc = 0;
      m_interrupt = 0; s_interrupt = 0; u_interrupt = 0; u_soft = 0;
      m_timer = 0; s_timer = 0; u_timer = 0;
      m_eie = 0; m_tie = 0; s_eie = 0; s_tie = 0; u_eie = 0; u_tie = 0; u_sie = 0;
   endtask

   task automatic random_lines();
      {m_interrupt, s_interrupt, u_interrupt, u_soft, m_timer, s_timer, u_timer} = 7'($urandom);
      {m_eie, m_tie, s_eie, s_tie, u_eie, u_tie, u_sie} = 7'($urandom);
   endtask

   task automatic random_junk();
      exc_valid = 1'($urandom); ret_valid = 1'($urandom); commit_valid = 1'($urandom);
      exc_code = 5'($urandom); exc_pc = $urandom; ret_type = 2'($urandom);
      commit_pc = $urandom;
      random_lines();
   endtask

   task automatic idle(input int n);
      clear_inputs();
      repeat (n) step();
   endtask

   // Runs one accepted event from the inputs driven now (IDLE cycle) through
   // flush (d extra cycles before flush_ack) and strobe, back to IDLE.
   task automatic do_event(input int d, input string name);
      logic [2:0] exp_rets;
      exp_rets = 3'b000;
      if (exc_valid) begin
         exp_cause = {27'd0, exc_code};
         exp_pc    = exc_pc;
      end else if (ret_valid) begin
         exp_rets = (ret_type == 2'b00) ? 3'b001 : (ret_type == 2'b01) ? 3'b010 : 3'b100;
      end else begin
         exp_cause = int_cause(pend_vec());
         exp_pc    = commit_pc;
      end
      step();
      n_checks++;
      if ({ready, flush_req, exception_pending} !== 3'b010) begin
         n_fail++;
         $display("FAIL %s accept: ready/flush_req/exc_pend=%b expected 010", name,
                  {ready, flush_req, exception_pending});
      end
      random_junk();
      for (int k = 0; k < d; k++) begin
         flush_ack = 0;
         step();
         n_checks++;
         if ({flush_req, exception_pending} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s flush_hold: flush_req/exc_pend=%b expected 10", name,
                     {flush_req, exception_pending});
         end
      end
      flush_ack = 1;
      step();
      clear_inputs();
      n_checks++;
      if ({flush_req, ready, exception_pending, redirect} !== 4'b0011) begin
         n_fail++;
         $display("FAIL %s strobe: flush_req/ready/exc_pend/redirect=%b expected 0011", name,
                  {flush_req, ready, exception_pending, redirect});
      end
      n_checks++;
      if (cause !== exp_cause) begin
         n_fail++;
         $display("FAIL %s cause: got %h expected %h", name, cause, exp_cause);
      end
      n_checks++;
      if (pc_exc !== exp_pc) begin
         n_fail++;
         $display("FAIL %s pc_exc: got %h expected %h", name, pc_exc, exp_pc);
      end
      n_checks++;
      if ({m_ret, s_ret, u_ret} !== exp_rets) begin
         n_fail++;
         $display("FAIL %s rets: got %b expected %b", name, {m_ret, s_ret, u_ret}, exp_rets);
      end
      step();
      n_checks++;
      if ({ready, flush_req, exception_pending} !== 3'b100) begin
         n_fail++;
         $display("FAIL %s return_idle: ready/flush_req/exc_pend=%b expected 100", name,
                  {ready, flush_req, exception_pending});
      end
      $display("txn %s: flush_wait=%0d cause=%h pc_exc=%h rets=%b", name, d, exp_cause,
               exp_pc, exp_rets);
   endtask

   // Checks that the pending interrupt is held off for the given IDLE cycles
   task automatic expect_blocked(input int n, input string name);
      for (int k = 0; k < n; k++) begin
         step();
         n_checks++;
         if ({ready, flush_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s blocked: ready/flush_req=%b expected 10 (idle cycle %0d)",
                     name, {ready, flush_req}, k);
         end
      end
   endtask

   task automatic test_reset();
      nrst = 0;
      random_junk();
      flush_ack = 1'($urandom);
      repeat (2) step();
      n_checks++;
      if ({ready, flush_req, exception_pending, redirect, m_ret, s_ret, u_ret} !== 7'b1000000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 1000000",
                  {ready, flush_req, exception_pending, redirect, m_ret, s_ret, u_ret});
      end
      n_checks++;
      if ({cause, pc_exc} !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_regs: cause=%h pc_exc=%h expected zero", cause, pc_exc);
      end
      clear_inputs();
      nrst = 1;
      step();
      // Abort in FLUSH
      exc_valid = 1; exc_code = 5'd5; exc_pc = $urandom;
      step();
      clear_inputs();
      n_checks++;
      if (flush_req !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_pre_abort: flush_req=%b expected 1", flush_req);
      end
      #2 nrst = 0;
      #1;
      exp_cause = 32'd0;
      exp_pc    = 32'd0;
      n_checks++;
      if ({ready, flush_req, cause} !== {2'b10, 32'd0}) begin
         n_fail++;
         $display("FAIL reset_abort: ready/flush_req=%b cause=%h expected 10 / 0",
                  {ready, flush_req}, cause);
      end
      step();
      nrst = 1;
      flush_ack = 1;
      repeat (2) begin
         step();
         n_checks++;
         if ({ready, flush_req, exception_pending} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_release: ready/flush_req/exc_pend=%b expected 100",
                     {ready, flush_req, exception_pending});
         end
      end
      flush_ack = 0;
      $display("txn reset: abort in FLUSH done");
   endtask

   task automatic test_exception();
      exc_valid = 1; exc_code = 5'd2; exc_pc = 32'h100;
      do_event(2, "exc_directed");
      for (int i = 0; i < 8; i++) begin
         random_junk();
         exc_valid = 1;
         do_event(int'($urandom_range(0, 3)), "exc_random");
      end
   endtask

   task automatic test_interrupt();
      idle(HOLDOFF);
      m_timer = 1; m_tie = 1; s_interrupt = 1; s_eie = 1;
      commit_pc = 32'h200;
      commit_valid = 0;
      expect_blocked(1, "int_no_commit");
      commit_valid = 1;
      do_event(0, "int_directed");
      for (int i = 0; i < 10; i++) begin
         idle(HOLDOFF);
         do random_lines(); while (pend_vec() == 7'd0);
         commit_valid = 1;
         commit_pc = $urandom;
         do_event(int'($urandom_range(0, 3)), "int_random");
      end
   endtask

   task automatic test_return();
      ret_valid = 1; ret_type = 2'b01;
      do_event(1, "ret_directed");
      for (int i = 0; i < 8; i++) begin
         random_lines();
         commit_valid = 1'($urandom);
         commit_pc = $urandom;
         ret_valid = 1;
         ret_type = 2'($urandom);
         do_event(int'($urandom_range(0, 2)), "ret_random");
      end
   endtask

   task automatic test_holdoff();
      idle(HOLDOFF);
      for (int i = 0; i < 3; i++) begin
         m_interrupt = 1; m_eie = 1; commit_valid = 1; commit_pc = 32'h300 + 32'(i * 4);
         if (i > 0) expect_blocked(HOLDOFF, "holdoff_int");
         do_event(0, "holdoff_int");
      end
      exc_valid = 1; exc_code = 5'd13; exc_pc = 32'h400;
      do_event(0, "holdoff_exc");
   endtask

   task automatic test_back_to_back();
      idle(HOLDOFF);
      exc_valid = 1; exc_code = 5'd7; exc_pc = 32'h500;
      ret_valid = 1; ret_type = 2'b11;
      u_soft = 1; u_sie = 1; commit_valid = 1; commit_pc = 32'h600;
      do_event(1, "simul_exc");
      u_soft = 1; u_sie = 1; commit_valid = 1; commit_pc = 32'h604;
      expect_blocked(HOLDOFF, "simul_followup");
      do_event(0, "simul_int");
   endtask

   // Continuous rules: strobes never back-to-back, ret strobes one-hot
   always @(negedge clk) begin
      if (nrst) begin
         n_checks++;
         if (prev_strobe && exception_pending) begin
            n_fail++;
            $display("FAIL strobe_spacing: exc_pend=%b in cycle after a strobe", exception_pending);
         end
         n_checks++;
         if ((m_ret | s_ret | u_ret) &&
             !(exception_pending && $onehot({m_ret, s_ret, u_ret}))) begin
            n_fail++;
            $display("FAIL ret_onehot: rets=%b exc_pend=%b", {m_ret, s_ret, u_ret}, exception_pending);
         end
         prev_strobe = exception_pending;
      end else begin
         prev_strobe = 1'b0;
      end
   end

   initial begin
      clear_inputs();
      nrst = 0;
      test_reset();
      test_exception();
      test_interrupt();
      test_return();
      test_holdoff();
      test_back_to_back();
      idle(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Trap and return sequencer that sits between the pipeline back end and `csr_regfile`. It prioritises synchronous exceptions, pending enabled interrupts and xRET requests, and drains the pipeline through a flush handshake. It then drives `exception_pending`, `cause`, `pc_exc` and `m_ret`/`s_ret`/`u_ret` into the CSR file for exactly one cycle, while pulsing `redirect` so the front end loads `epc`. A holdoff counter blocks interrupts for a few cycles after each redirect so the handler's first instructions always make progress.

## Interface
- `HOLDOFF`, default 2: cycles after a redirect during which interrupts are not accepted. Valid range 0..15.
- `clk`  in  1  clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `exc_valid`  in  1  a synchronous exception is reported by the commit stage.
- `exc_code`  in  5  exception code.
- `exc_pc`  in  32  PC of the faulting instruction.
- `ret_valid`  in  1  an xRET instruction is at commit.
- `ret_type`  in  2  which xRET: 11 = MRET, 01 = SRET, 00 = URET.
- `commit_valid`  in  1  the commit stage holds a valid instruction, so an interrupt may be taken.
- `commit_pc`  in  32  PC of the instruction at commit, saved as the interrupt EPC.
- `m_interrupt`, `s_interrupt`, `u_interrupt`, `u_soft`  in  1 each  external and software pending lines.
- `m_timer`, `s_timer`, `u_timer`  in  1 each  timer pending flags from `csr_regfile`.
- `m_eie`, `m_tie`, `s_eie`, `s_tie`, `u_eie`, `u_tie`, `u_sie`  in  1 each  enables from `csr_regfile`, already ANDed with the xIE bits.
- `flush_ack`  in  1  the pipeline has drained.
- `flush_req`  out  1  request a pipeline flush.
- `ready`  out  1  the sequencer is IDLE and accepting events.
- `exception_pending`  out  1  trap or return strobe to `csr_regfile`.
- `cause`  out  32  mcause-format cause.
- `pc_exc`  out  32  EPC value to save.
- `m_ret`, `s_ret`, `u_ret`  out  1 each  return strobes.
- `redirect`  out  1  front end loads `epc` this cycle.

## Operation
- FSM states: IDLE, FLUSH, TRAP, RET.
- The FSM is Moore: outputs decode from the state register and the latched registers.
- Interrupt pending vector:
  - MEI(11) = `m_interrupt & m_eie`
  - MTI(7) = `m_timer & m_tie`
  - SEI(9) = `s_interrupt & s_eie`
  - STI(5) = `s_timer & s_tie`
  - UEI(8) = `u_interrupt & u_eie`
  - USI(0) = `u_soft & u_sie`
  - UTI(4) = `u_timer & u_tie`
- Interrupt priority: MEI > MTI > SEI > STI > UEI > USI > UTI. The highest-priority pending interrupt is chosen.
- IDLE arbitration, evaluated once per cycle, highest priority first:
  1. `exc_valid`:
     - latch `cause = {1'b0, 26'b0, exc_code}` and `pc_exc = exc_pc`;
     - `kind = TRAP`;
     - go to FLUSH.
  2. `ret_valid`:
     - latch `ret_type`;
     - `kind = RET`;
     - go to FLUSH.
  3. An interrupt is pending, `commit_valid = 1` and `holdoff_cnt == 0`:
     - latch `cause = {1'b1, 26'b0, code}` and `pc_exc = commit_pc`;
     - `kind = TRAP`;
     - go to FLUSH.
- FLUSH: hold `flush_req = 1`. When `flush_ack` is sampled high, go to TRAP or RET according to `kind`.
- TRAP: assert `exception_pending = 1` and `redirect = 1` for one cycle, load `holdoff_cnt = HOLDOFF`, then return to IDLE.
- RET:
  - assert `exception_pending = 1`, `redirect = 1`, and exactly one of `m_ret`/`s_ret`/`u_ret`, for one cycle;
  - load `holdoff_cnt = HOLDOFF`;
  - return to IDLE.
  - `exception_pending` is required during RET because `csr_regfile` only switches privilege mode when it is high.
- `holdoff_cnt` is 4 bits. It decrements by 1 per cycle in IDLE while non-zero and saturates at 0. It gates interrupts only; exceptions and returns ignore it.
- Inputs arriving while the FSM is not in IDLE are ignored. The pipeline is being flushed and re-presents any surviving event.
- `cause` and `pc_exc` hold their latched value until the next accept.
- `ret_type = 10` is illegal. It is accepted as MRET.

## Timing
- Reset: state = IDLE, `holdoff_cnt = 0`, `cause = 0`, `pc_exc = 0`, all strobes 0, `flush_req = 0`, `ready = 1`.
- Reset asserted mid-sequence aborts immediately: no strobe is issued, and the FSM is in IDLE on release.
- Latency: event sampled at edge N → `flush_req` high from N+1 → `flush_ack` sampled at edge M → strobe cycle between edges M and M+1 → IDLE at M+1. With `flush_ack` tied high, the strobe falls in the window between edges N+1 and N+2.
- `flush_req` drops in the same edge that enters TRAP or RET.
- Simultaneous exception and interrupt: the exception wins. The interrupt, being level-sensitive, is re-arbitrated after the holdoff.
- Simultaneous `exc_valid` and `ret_valid`: the exception wins.
- An interrupt that deasserts during FLUSH is still taken, because its cause was latched at the accept edge.
- HOLDOFF = 0: an interrupt may be accepted on the first IDLE cycle after the strobe.
- Strobes are never asserted in back-to-back cycles.

## Test plan
- Reset with inputs driven: all outputs at reset values, `ready = 1`. Assert `nrst` low while in FLUSH → next cycle IDLE, no strobe.
- Exception: `exc_valid`, `exc_code = 2`, `exc_pc = 0x100`, `flush_ack` 3 cycles later → `flush_req` high 3 cycles, then one cycle with `exception_pending = 1`, `cause = 0x00000002`, `pc_exc = 0x100`, `redirect = 1`.
- Interrupt priority: `m_timer & m_tie` and `s_interrupt & s_eie` both pending, `commit_pc = 0x200`, `flush_ack = 1` → `cause = 0x80000007`, `pc_exc = 0x200`.
- Holdoff: HOLDOFF = 2, `m_interrupt & m_eie` held high → interrupt strobes occur no closer than 1 strobe + 1 FLUSH + 2 holdoff cycles apart. `exc_valid` raised during holdoff is accepted immediately.
- Return: `ret_valid`, `ret_type = 01` → a single cycle with `s_ret = 1`, `exception_pending = 1`, `redirect = 1`, `m_ret = u_ret = 0`.
- Simultaneous: `exc_valid` + `ret_valid` + a pending interrupt in one cycle → exception strobe only. The interrupt follows after HOLDOFF; `ret_valid` must be re-presented by the pipeline.
